// File: rtl/mycpu_pkg.sv
// Shared decode constants for the mycpu ID stage.
//   - MIPS opcode and funct field encodings for the supported subset
//   - ALU one-hot bit indices (ALU_OP_W bits wide)
//   - operand-select and branch-class enums used between decoder and stage
package mycpu_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_LUI     = 6'h0f;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2b;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2a;
   localparam logic [5:0] FN_SLTU = 6'h2b;

   localparam int unsigned ALU_OP_W    = 12;
   localparam int unsigned ALU_OP_ADD  = 0;
   localparam int unsigned ALU_OP_SUB  = 1;
   localparam int unsigned ALU_OP_SLT  = 2;
   localparam int unsigned ALU_OP_SLTU = 3;
   localparam int unsigned ALU_OP_AND  = 4;
   localparam int unsigned ALU_OP_NOR  = 5;
   localparam int unsigned ALU_OP_OR   = 6;
   localparam int unsigned ALU_OP_XOR  = 7;
   localparam int unsigned ALU_OP_SLL  = 8;
   localparam int unsigned ALU_OP_SRL  = 9;
   localparam int unsigned ALU_OP_SRA  = 10;
   localparam int unsigned ALU_OP_LUI  = 11;

   typedef enum logic [1:0] {Src1Rs, Src1Sa, Src1Pc} src1_sel_e;
   typedef enum logic [1:0] {Src2Rt, Src2Simm, Src2Zimm, Src2Eight} src2_sel_e;
   typedef enum logic [2:0] {BrNone, BrBeq, BrBne, BrJal, BrJr} br_type_e;

endpackage

// File: rtl/mycpu_id_stage_if.sv
// IF -> ID handshake bundle.
//   fetch drives: fs_to_ds_valid, fs_pc, fs_inst
//   decode drives: ds_allowin, br_taken, br_target (redirect back to fetch)
interface mycpu_id_stage_if;
   logic        fs_to_ds_valid;
   logic [31:0] fs_pc;
   logic [31:0] fs_inst;
   logic        ds_allowin;
   logic        br_taken;
   logic [31:0] br_target;

   modport master (
      output fs_to_ds_valid, fs_pc, fs_inst,
      input  ds_allowin, br_taken, br_target
   );

   modport slave (
      input  fs_to_ds_valid, fs_pc, fs_inst,
      output ds_allowin, br_taken, br_target
   );
endinterface

// File: rtl/mycpu_id_decoder.sv
// Combinational instruction decoder.
//   inst_i      : latched instruction word
//   alu_op_o    : one-hot ALU operation
//   src*_sel_o  : operand source selects
//   dest_o      : writeback register, 0 = none
//   rs/rt_used_o: register operands that participate in hazard detection
//   mem_we_o, load_o, br_type_o, unknown_o : instruction class
module mycpu_id_decoder
   import mycpu_pkg::*;
(
   input  logic [31:0]         inst_i,
   output logic [ALU_OP_W-1:0] alu_op_o,
   output src1_sel_e           src1_sel_o,
   output src2_sel_e           src2_sel_o,
   output logic [4:0]          dest_o,
   output logic                rs_used_o,
   output logic                rt_used_o,
   output logic                mem_we_o,
   output logic                load_o,
   output br_type_e            br_type_o,
   output logic                unknown_o
);

   logic [5:0] op;
   logic [5:0] funct;
   logic [4:0] rt;
   logic [4:0] rd;

   assign op    = inst_i[31:26];
   assign funct = inst_i[5:0];
   assign rt    = inst_i[20:16];
   assign rd    = inst_i[15:11];

   always_comb begin
      alu_op_o   = '0;
      src1_sel_o = Src1Rs;
      src2_sel_o = Src2Rt;
      dest_o     = 5'd0;
      rs_used_o  = 1'b0;
      rt_used_o  = 1'b0;
      mem_we_o   = 1'b0;
      load_o     = 1'b0;
      br_type_o  = BrNone;
      unknown_o  = 1'b0;
      case (op)
         OP_SPECIAL: begin
            rs_used_o = 1'b1;
            rt_used_o = 1'b1;
            dest_o    = rd;
            case (funct)
               FN_ADDU: alu_op_o[ALU_OP_ADD]  = 1'b1;
               FN_SUBU: alu_op_o[ALU_OP_SUB]  = 1'b1;
               FN_SLT:  alu_op_o[ALU_OP_SLT]  = 1'b1;
               FN_SLTU: alu_op_o[ALU_OP_SLTU] = 1'b1;
               FN_AND:  alu_op_o[ALU_OP_AND]  = 1'b1;
               FN_OR:   alu_op_o[ALU_OP_OR]   = 1'b1;
               FN_XOR:  alu_op_o[ALU_OP_XOR]  = 1'b1;
               FN_NOR:  alu_op_o[ALU_OP_NOR]  = 1'b1;
               FN_SLL: begin
                  alu_op_o[ALU_OP_SLL] = 1'b1;
                  src1_sel_o           = Src1Sa;
               end
               FN_SRL: begin
                  alu_op_o[ALU_OP_SRL] = 1'b1;
                  src1_sel_o           = Src1Sa;
               end
               FN_SRA: begin
                  alu_op_o[ALU_OP_SRA] = 1'b1;
                  src1_sel_o           = Src1Sa;
               end
               FN_JR: begin
                  dest_o    = 5'd0;
                  rt_used_o = 1'b0;
                  br_type_o = BrJr;
               end
               default: begin
                  // Unsupported funct flows through as a nop.
                  unknown_o = 1'b1;
                  dest_o    = 5'd0;
                  rs_used_o = 1'b0;
                  rt_used_o = 1'b0;
               end
            endcase
         end
         OP_ADDIU: begin
            alu_op_o[ALU_OP_ADD] = 1'b1;
            src2_sel_o           = Src2Simm;
            dest_o               = rt;
            rs_used_o            = 1'b1;
         end
         OP_LUI: begin
            alu_op_o[ALU_OP_LUI] = 1'b1;
            src2_sel_o           = Src2Zimm;
            dest_o               = rt;
         end
         OP_LW: begin
            alu_op_o[ALU_OP_ADD] = 1'b1;
            src2_sel_o           = Src2Simm;
            dest_o               = rt;
            rs_used_o            = 1'b1;
            load_o               = 1'b1;
         end
         OP_SW: begin
            alu_op_o[ALU_OP_ADD] = 1'b1;
            src2_sel_o           = Src2Simm;
            rs_used_o            = 1'b1;
            rt_used_o            = 1'b1;
            mem_we_o             = 1'b1;
         end
         OP_BEQ: begin
            rs_used_o = 1'b1;
            rt_used_o = 1'b1;
            br_type_o = BrBeq;
         end
         OP_BNE: begin
            rs_used_o = 1'b1;
            rt_used_o = 1'b1;
            br_type_o = BrBne;
         end
         OP_JAL: begin
            // Link value pc+8 is computed by the ALU.
            alu_op_o[ALU_OP_ADD] = 1'b1;
            src1_sel_o           = Src1Pc;
            src2_sel_o           = Src2Eight;
            dest_o               = 5'd31;
            br_type_o            = BrJal;
         end
         default: unknown_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/mycpu_id_stage.sv
// Instruction-decode stage: owns the IF/ID register, reads the register file, stalls on
// RAW hazards against EX/MEM/WB destinations (no forwarding), resolves branches with
// delay-slot semantics and hands a decoded bundle to EX.
//   clk, resetn   : clock, async active-low reset
//   fs_if         : fetch-side handshake and branch redirect
//   rf_*          : register file read port pair (rs, rt)
//   es/ms/ws_dest : in-flight destination registers, 0 = none
//   es_allowin    : EX back-pressure
//   ds_*          : decoded bundle toward EX
module mycpu_id_stage
   import mycpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC_INST = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                resetn,
   mycpu_id_stage_if.slave     fs_if,
   output logic [4:0]          rf_raddr1,
   output logic [4:0]          rf_raddr2,
   input  logic [31:0]         rf_rdata1,
   input  logic [31:0]         rf_rdata2,
   input  logic [4:0]          es_dest,
   input  logic [4:0]          ms_dest,
   input  logic [4:0]          ws_dest,
   input  logic                es_allowin,
   output logic                ds_to_es_valid,
   output logic [31:0]         ds_pc,
   output logic [ALU_OP_W-1:0] ds_alu_op,
   output logic [31:0]         ds_src1,
   output logic [31:0]         ds_src2,
   output logic [4:0]          ds_dest,
   output logic                ds_mem_we,
   output logic                ds_load,
   output logic [31:0]         ds_store_data,
   output logic                ds_unknown
);

   logic        ds_valid_q, ds_valid_d;
   logic [31:0] ds_pc_q, ds_pc_d;
   logic [31:0] ds_inst_q, ds_inst_d;

   src1_sel_e   src1_sel;
   src2_sel_e   src2_sel;
   br_type_e    br_type;
   logic        rs_used, rt_used;
   logic [4:0]  rs, rt;
   logic [15:0] imm;
   logic        rs_hit, rt_hit, stall, ds_ready_go, br_cond;
   logic [31:0] pc_plus4, simm;

   mycpu_id_decoder u_decoder (
      .inst_i     (ds_inst_q),
      .alu_op_o   (ds_alu_op),
      .src1_sel_o (src1_sel),
      .src2_sel_o (src2_sel),
      .dest_o     (ds_dest),
      .rs_used_o  (rs_used),
      .rt_used_o  (rt_used),
      .mem_we_o   (ds_mem_we),
      .load_o     (ds_load),
      .br_type_o  (br_type),
      .unknown_o  (ds_unknown)
   );

   assign rs        = ds_inst_q[25:21];
   assign rt        = ds_inst_q[20:16];
   assign imm       = ds_inst_q[15:0];
   assign rf_raddr1 = rs;
   assign rf_raddr2 = rt;
   assign simm      = {{16{imm[15]}}, imm};
   assign pc_plus4  = ds_pc_q + 32'd4;

   // Register 0 never creates a hazard; matching a nonzero reg implies a nonzero dest.
   assign rs_hit = (rs != 5'd0) && ((rs == es_dest) || (rs == ms_dest) || (rs == ws_dest));
   assign rt_hit = (rt != 5'd0) && ((rt == es_dest) || (rt == ms_dest) || (rt == ws_dest));
   assign stall  = ds_valid_q && ((rs_used && rs_hit) || (rt_used && rt_hit));

   assign ds_ready_go      = !stall;
   assign fs_if.ds_allowin = !ds_valid_q || (ds_ready_go && es_allowin);
   assign ds_to_es_valid   = ds_valid_q && ds_ready_go;
   assign ds_pc            = ds_pc_q;
   assign ds_store_data    = rf_rdata2;

   always_comb begin
      ds_src1 = rf_rdata1;
      unique case (src1_sel)
         Src1Sa:  ds_src1 = {27'b0, ds_inst_q[10:6]};
         Src1Pc:  ds_src1 = ds_pc_q;
         default: ds_src1 = rf_rdata1;
      endcase
      ds_src2 = rf_rdata2;
      unique case (src2_sel)
         Src2Simm:  ds_src2 = simm;
         Src2Zimm:  ds_src2 = {16'b0, imm};
         Src2Eight: ds_src2 = 32'd8;
         default:   ds_src2 = rf_rdata2;
      endcase
   end

   always_comb begin
      br_cond         = 1'b0;
      fs_if.br_target = pc_plus4 + {simm[29:0], 2'b00};
      case (br_type)
         BrBeq: br_cond = (rf_rdata1 == rf_rdata2);
         BrBne: br_cond = (rf_rdata1 != rf_rdata2);
         BrJal: begin
            br_cond         = 1'b1;
            fs_if.br_target = {pc_plus4[31:28], ds_inst_q[25:0], 2'b00};
         end
         BrJr: begin
            br_cond         = 1'b1;
            fs_if.br_target = rf_rdata1;
         end
         default: br_cond = 1'b0;
      endcase
   end

   // Redirect only in the handoff cycle so a stalled branch is not taken twice.
   assign fs_if.br_taken = ds_valid_q && ds_ready_go && es_allowin && br_cond;

   always_comb begin
      ds_valid_d = ds_valid_q;
      ds_pc_d    = ds_pc_q;
      ds_inst_d  = ds_inst_q;
      if (fs_if.ds_allowin) begin
         ds_valid_d = fs_if.fs_to_ds_valid;
         if (fs_if.fs_to_ds_valid) begin
            ds_pc_d   = fs_if.fs_pc;
            ds_inst_d = fs_if.fs_inst;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ds_valid_q <= 1'b0;
         ds_pc_q    <= 32'd0;
         ds_inst_q  <= RESET_PC_INST;
      end else begin
         ds_valid_q <= ds_valid_d;
         ds_pc_q    <= ds_pc_d;
         ds_inst_q  <= ds_inst_d;
      end
   end

endmodule

// File: doc/mycpu_id_stage.md
Name: mycpu_id_stage

Overview:
Instruction-decode stage directly downstream of the fetch stage. It owns the IF/ID pipeline register and reads operands from the register file. It detects read-after-write hazards and stalls on them, resolves branches and jumps (the fetch stage takes the redirect), and hands a decoded bundle to EX. It uses a valid/allowin handshake on both sides and follows MIPS delay-slot semantics, so nothing is flushed on a branch.

Parameters:
RESET_PC_INST, 32'h0000_0000, value loaded into the latched instruction on reset (encodes sll $0,$0,0, a nop)

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
fs_to_ds_valid  in  1  fetch stage presents a valid instruction
fs_pc  in  32  PC of the presented instruction
fs_inst  in  32  instruction word (the inst_sram_rdata path)
ds_allowin  out  1  ID stage can accept this cycle
br_taken  out  1  redirect fetch to br_target
br_target  out  32  redirect address
rf_raddr1  out  5  register file read address, rs
rf_raddr2  out  5  register file read address, rt
rf_rdata1  in  32  combinational read data for rs
rf_rdata2  in  32  combinational read data for rt
es_dest  in  5  destination register of the valid EX instruction, 0 = none
ms_dest  in  5  destination register of the valid MEM instruction, 0 = none
ws_dest  in  5  destination register of the valid WB instruction, 0 = none
es_allowin  in  1  EX stage can accept
ds_to_es_valid  out  1  bundle valid toward EX
ds_pc  out  32  PC of the decoded instruction
ds_alu_op  out  12  one-hot: add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui (bit 0..11)
ds_src1  out  32  ALU operand 1
ds_src2  out  32  ALU operand 2
ds_dest  out  5  writeback register, 0 = no write
ds_mem_we  out  1  store
ds_load  out  1  load
ds_store_data  out  32  rt value for SW
ds_unknown  out  1  reserved or unsupported instruction

Behaviour:
- Reset (async, resetn=0):
  - ds_valid=0, ds_pc=0, latched inst=RESET_PC_INST.
  - Consequently ds_to_es_valid=0, br_taken=0, ds_allowin=1.
- Handshake:
  - ds_ready_go = !stall.
  - ds_allowin = !ds_valid || (ds_ready_go && es_allowin).
  - ds_to_es_valid = ds_valid && ds_ready_go.
- Register update:
  - On clk edge with ds_allowin: ds_valid<=fs_to_ds_valid.
  - If fs_to_ds_valid is also set, latch fs_pc and fs_inst; otherwise pc/inst hold.
  - Latency: one cycle, fetch accept to decode.
- Supported instructions: ADDU SUBU SLT SLTU AND OR XOR NOR SLL SRL SRA ADDIU LUI LW SW BEQ BNE JAL JR.
- Anything else: ds_unknown=1, ds_dest=0, ds_mem_we=0, ds_load=0, br_taken=0. The instruction flows as a nop.
- Operand rules:
  - R-type ALU: src1=rs, src2=rt, dest=rd.
  - Shifts: src1={27'b0,sa}, src2=rt.
  - ADDIU/LW/SW: src2=sign-extend(imm).
  - LUI: src2={16'b0,imm}, dest=rt.
  - JAL: alu add, src1=pc, src2=8, dest=31.
  - SW, BEQ, BNE, JR: dest=0.
- Hazard / stall:
  - stall when ds_valid and (rs is used and rs!=0 and rs equals any nonzero es/ms/ws_dest), or the same condition for rt.
  - rs is used by R-type, ADDIU, LW, SW, BEQ, BNE, JR. rt is used by R-type, SW, BEQ, BNE.
  - No forwarding.
  - During a stall, inst/pc hold and ds_allowin=0.
- Branches:
  - br_taken = ds_valid && ds_ready_go && es_allowin && condition. It is asserted only in the handoff cycle.
  - BEQ condition: rs==rt. BNE condition: rs!=rt. JAL and JR: always taken.
  - BEQ/BNE target: pc+4+(sext(imm)<<2). JAL target: {pc[31:28]+carry from pc+4, index, 2'b00}, i.e. {(pc+4)[31:28], index, 2'b00}. JR target: rs value.
  - All address arithmetic is modulo 2^32.
  - The delay slot in IF is accepted normally; fetch redirects after it.
- Simultaneous events: stall and an upstream valid in the same cycle means the upstream instruction is not accepted and the held instruction is kept.
- Reset mid-stall: discards the held instruction immediately.

Decomposition:
- Package mycpu_pkg:
  - opcode constants: SPECIAL, ADDIU, LUI, LW, SW, BEQ, BNE, JAL.
  - funct constants: ADDU, SUBU, SLT, SLTU, AND, OR, XOR, NOR, SLL, SRL, SRA, JR.
  - ALU_OP_* bit indices and ALU_OP_W=12.
- Sub-module mycpu_id_decoder (combinational): inst → alu_op, src select, dest, rs/rt-used flags, mem/branch class, unknown flag.

Test Plan:
- Reset: hold resetn=0 → ds_allowin=1, ds_to_es_valid=0, br_taken=0. Release, then present ADDIU $2,$0,5 at pc=0xBFC00000 → next cycle ds_to_es_valid=1, alu add, src2=5, dest=2.
- RAW stall: ID holds ADDU $3,$2,$2 with es_dest=2 for 2 cycles → ds_allowin=0 and ds_to_es_valid=0 for those 2 cycles. With es_dest=0 → handoff, src1=src2=rf_rdata1.
- BEQ taken: rs=rt=0x1234, pc=0x100, imm=0xFFFF, es_allowin=1 → br_taken=1, br_target=0x100. Same case with es_allowin=0 → br_taken=0 and the instruction holds.
- JAL/JR: JAL index 0x40 at pc=0xBFC00010 → target 0xB0000100, dest=31, src1=pc, src2=8. JR with rs=0x80 → target 0x80, dest=0.
- Back-pressure: es_allowin=0 for 3 cycles with fs_to_ds_valid=1 → ID holds its instruction and does not latch the new one. Release → both transfer in order.
- Unknown opcode 0x3F → ds_unknown=1, ds_dest=0, ds_mem_we=0, flows to EX. Assert resetn=0 mid-stall → ds_valid=0 immediately.
